// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O target for the core load/store port: switches, debounced
// buttons with sticky W1C edge flags, and an eight-digit seven-segment display.
module mmio_io_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic [15:0] switch_array,
  input  logic        button0,
  input  logic        button1,
  input  logic        button2,
  input  logic        button3,
  output logic [6:0]  seg0,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4,
  output logic [6:0]  seg5,
  output logic [6:0]  seg6,
  output logic [6:0]  seg7
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  4'hF: f = 7'h0E;
      default: f = 7'h7F;
    endcase
    return f;
  endfunction

  state_e          state_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_error_q;
  logic [15:0]     sw_meta_q, sw_sync_q;
  logic [3:0]      btn_meta_q, btn_sync_q;
  logic [3:0]      deb_q, deb_d;
  logic [CW-1:0]   cnt_q [4];
  logic [CW-1:0]   cnt_d [4];
  logic [3:0]      flags_q, flags_d;
  logic [31:0]     hex_q;
  logic [7:0]      seg_en_q;
  logic [6:0]      seg_q [8];

  logic            hit_s, err_s, accept_s, wr_ok_s;
  logic [2:0]      reg_sel_s;
  logic [31:0]     rdata_s;
  logic [3:0]      rise_s, clr_s;
  logic [3:0]      btn_raw_s;

  assign btn_raw_s = {button3, button2, button1, button0};
  assign reg_sel_s = req_addr[4:2];
  assign hit_s     = (req_addr[31:5] == BASE_ADDR[31:5]);
  assign err_s     = (req_addr[1:0] != 2'b00) || !hit_s || (reg_sel_s > 3'd4);
  assign req_ready = rst && (state_q == IDLE);
  assign accept_s  = req_valid && req_ready;
  assign wr_ok_s   = accept_s && req_write && !err_s;

  // Read mux; erroring accesses return zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!err_s) begin
      case (reg_sel_s)
        3'd0:    rdata_s = {16'h0000, sw_sync_q};
        3'd1:    rdata_s = {28'h000_0000, deb_q};
        3'd2:    rdata_s = {28'h000_0000, flags_q};
        3'd3:    rdata_s = hex_q;
        3'd4:    rdata_s = {24'h00_0000, seg_en_q};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Debounce: a button flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      if (btn_sync_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i] = btn_sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise_s = deb_d & ~deb_q;
  end

  // Sticky edge flags; a new rising edge beats a simultaneous clear.
  always_comb begin
    if (wr_ok_s && (reg_sel_s == 3'd2)) begin
      clr_s = req_wdata[3:0];
    end else begin
      clr_s = 4'h0;
    end
    flags_d = (flags_q & ~clr_s) | rise_s;
  end

  // Input synchronisers and debounce state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_meta_q  <= 16'h0000;
      sw_sync_q  <= 16'h0000;
      btn_meta_q <= 4'h0;
      btn_sync_q <= 4'h0;
      deb_q      <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sw_meta_q  <= switch_array;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_raw_s;
      btn_sync_q <= btn_meta_q;
      deb_q      <= deb_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Writable registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hex_q    <= 32'h0000_0000;
      seg_en_q <= 8'hFF;
      flags_q  <= 4'h0;
    end else begin
      if (wr_ok_s && (reg_sel_s == 3'd3)) hex_q <= req_wdata;
      if (wr_ok_s && (reg_sel_s == 3'd4)) seg_en_q <= req_wdata[7:0];
      flags_q <= flags_d;
    end
  end

  // Registered segment drivers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) seg_q[i] <= 7'h40;
    end else begin
      for (int i = 0; i < 8; i++)
        seg_q[i] <= seg_en_q[i] ? hex_font(hex_q[i*4 +: 4]) : 7'h7F;
    end
  end

  // Request/response FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_error_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_s;
            rsp_error_q <= err_s;
          end else begin
            rsp_valid_q <= 1'b0;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: tb/tb_mmio_io_responder.sv
// Scoreboard bench for mmio_io_responder: a cycle-level behavioural model pushes
// expected responses; a negedge monitor compares handshake, responses and segments.
module tb_mmio_io_responder;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int          DC   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] switch_array = 16'h0;
  logic [3:0]  btn = 4'h0;
  logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

  mmio_io_responder #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .switch_array(switch_array),
    .button0(btn[0]), .button1(btn[1]), .button2(btn[2]), .button3(btn[3]),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state
  typedef struct { logic [31:0] rd; logic err; } rsp_t;
  rsp_t        exp_q[$];
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  bit          m_resp = 1'b0;
  logic [15:0] m_sw1 = 16'h0, m_sw2 = 16'h0;
  logic [3:0]  m_b1 = 4'h0, m_b2 = 4'h0, m_deb = 4'h0, m_flags = 4'h0;
  int          m_run [4] = '{0, 0, 0, 0};
  logic [31:0] m_hex = 32'h0;
  logic [7:0]  m_en = 8'hFF;
  logic [6:0]  m_seg [8] = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  task automatic model_step();
    logic [6:0]  nseg [8];
    logic        acc, err;
    logic [4:0]  off;
    logic [31:0] rd;
    logic [3:0]  clr, rise;
    if (!rst) begin
      m_resp = 1'b0; m_sw1 = 16'h0; m_sw2 = 16'h0; m_b1 = 4'h0; m_b2 = 4'h0;
      m_deb = 4'h0; m_flags = 4'h0; m_hex = 32'h0; m_en = 8'hFF;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      for (int i = 0; i < 8; i++) m_seg[i] = 7'h40;
    end else begin
      for (int i = 0; i < 8; i++) nseg[i] = m_en[i] ? font[m_hex[i*4 +: 4]] : 7'h7F;
      acc = req_valid && !m_resp;
      clr = 4'h0;
      if (acc) begin
        off = req_addr[4:0];
        err = (req_addr[1:0] != 2'b00) || (req_addr[31:5] != BASE[31:5]) || (off >= 5'h14);
        rd  = 32'h0;
        if (!err) begin
          case (off)
            5'h00:   rd = {16'h0, m_sw2};
            5'h04:   rd = {28'h0, m_deb};
            5'h08:   rd = {28'h0, m_flags};
            5'h0C:   rd = m_hex;
            5'h10:   rd = {24'h0, m_en};
            default: rd = 32'h0;
          endcase
        end
        exp_q.push_back('{rd, err});
        if (req_write && !err) begin
          if (off == 5'h08) clr = req_wdata[3:0];
          if (off == 5'h0C) m_hex = req_wdata;
          if (off == 5'h10) m_en = req_wdata[7:0];
        end
      end
      rise = 4'h0;
      for (int b = 0; b < 4; b++) begin
        if (m_b2[b] == m_deb[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] == DC) begin
            m_deb[b] = m_b2[b];
            m_run[b] = 0;
            rise[b] = m_deb[b];
          end
        end
      end
      m_flags = (m_flags & ~clr) | rise;
      m_b2 = m_b1; m_b1 = btn;
      m_sw2 = m_sw1; m_sw1 = switch_array;
      for (int i = 0; i < 8; i++) m_seg[i] = nseg[i];
      m_resp = acc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      logic [55:0] act_seg, exp_seg;
      rsp_t e;
      act_seg = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};
      for (int i = 0; i < 8; i++) exp_seg[i*7 +: 7] = m_seg[i];
      chk("rsp_valid", rsp_valid, m_resp);
      chk("req_ready", req_ready, rst && !m_resp);
      chk("segments", act_seg, exp_seg);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rd);
          chk("rsp_error", rsp_error, e.err);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    chk("req_accept_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    wait_cyc(3);
    chk_en = 1'b1;
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    do_req(1'b0, BASE + 32'h0C, 32'h0);
    do_req(1'b0, BASE + 32'h10, 32'h0);
    do_req(1'b1, BASE + 32'h0C, 32'h1234ABCD);
    do_req(1'b0, BASE + 32'h0C, 32'h0);
    wait_cyc(2);
    chk("seg0_d", seg0, 7'h21);
    chk("seg1_C", seg1, 7'h46);
    chk("seg7_1", seg7, 7'h79);
    do_req(1'b1, BASE + 32'h10, 32'h0F);
    wait_cyc(2);
    chk("seg4_off", seg4, 7'h7F);
    chk("seg7_off", seg7, 7'h7F);
    switch_array = 16'hA5C3;
    wait_cyc(3);
    do_req(1'b0, BASE + 32'h00, 32'h0);
    do_req(1'b0, BASE + 32'h02, 32'h0);
    do_req(1'b0, BASE + 32'h14, 32'h0);
    do_req(1'b1, BASE + 32'h00, 32'hFFFF_FFFF);
    do_req(1'b0, BASE + 32'h00, 32'h0);
    do_req(1'b0, 32'h0000_100C, 32'h0);
    // button1 glitch, then a real press, then W1C clear
    btn[1] = 1'b1; wait_cyc(DC - 2); btn[1] = 1'b0; wait_cyc(DC + 4);
    do_req(1'b0, BASE + 32'h04, 32'h0);
    do_req(1'b0, BASE + 32'h08, 32'h0);
    btn[1] = 1'b1; wait_cyc(DC + 3);
    do_req(1'b0, BASE + 32'h04, 32'h0);
    do_req(1'b0, BASE + 32'h08, 32'h0);
    do_req(1'b1, BASE + 32'h08, 32'h2);
    do_req(1'b0, BASE + 32'h08, 32'h0);
    do_req(1'b0, BASE + 32'h04, 32'h0);
    // back-to-back reads with req_valid held high
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'h0C;
    wait_cyc(10);
    req_valid = 1'b0;
    wait_cyc(1);
    // reset while a response is being presented
    do_req(1'b0, BASE + 32'h10, 32'h0);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    do_req(1'b0, BASE + 32'h0C, 32'h0);
    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) switch_array = 16'($urandom);
      if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc($urandom_range(0, 3));
      end else begin
        a = BASE + {27'h0, 3'($urandom_range(0, 7)), 2'b00};
        if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) a = a ^ 32'h0000_0100;
        do_req(1'($urandom_range(0, 1)), a, $urandom);
      end
    end
    wait_cyc(5);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_io_responder.md
Name: mmio_io_responder

Overview:
- Memory-mapped I/O responder (target side) for the core's load/store port.
- Answers core read/write requests over a valid/ready request channel and a one-cycle response pulse.
- Exposes the board switches and buttons as readable registers; buttons are synchronised and debounced, with sticky edge flags.
- Drives the eight seven-segment digits from a writable hex register.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte base of the 32-byte register window; must be 32-byte aligned.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a debounced button changes (min 2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  load data, valid with rsp_valid
- rsp_error  output  1  decode or alignment error, valid with rsp_valid
- switch_array  input  16  raw asynchronous switches
- button0..button3  input  1 each  raw asynchronous buttons
- seg0..seg7  output  7 each  digit segments, active-low, bit order {g,f,e,d,c,b,a}; seg0 shows nibble [3:0]

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, HEX=0, SEG_EN=8'hFF, debounced buttons=0, edge flags=0, synchronisers=0, all seg outputs=7'h40 (digit "0").
- req_ready is forced to 0 while rst=0. Reset mid-transaction drops the pending response; no rsp_valid is issued.
- FSM IDLE: req_ready=1. On req_valid&&req_ready the request is accepted, captured, and the FSM goes to RESP.
- FSM RESP: req_ready=0, rsp_valid=1 for exactly this one cycle, then back to IDLE.
- Latency is 1 cycle (accept edge -> rsp_valid high the next cycle). Maximum throughput is 1 request per 2 cycles.
- Decode: the request hits when req_addr[31:5]==BASE_ADDR[31:5], and the offset is req_addr[4:0].
- Error: req_addr[1:0]!=0, no hit, or offset 0x14..0x1C gives rsp_error=1 and rsp_rdata=0; writes with error have no effect.
- 0x00 SWITCH, RO: {16'b0, 2-flop synchronised switches}. Writes are ignored, no error.
- 0x04 BUTTONS, RO: {28'b0, debounced[3:0]}, with button0 in bit 0.
- 0x08 BTN_EDGE, W1C: {28'b0, flags[3:0]}.
  - A flag is set on a 0->1 transition of its debounced button.
  - A write clears the bits where wdata=1.
  - A set and a clear in the same cycle: set wins.
- 0x0C HEX, RW: 32-bit display value.
- 0x10 SEG_EN, RW: [7:0] per-digit enable; upper bits read 0.
- Read data is sampled at the accept edge and presented in RESP. Writes update the register at the accept edge.
- Debounce, per button, after the 2-flop synchroniser:
  - Counter resets to 0 whenever synced==debounced.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, debounced<=synced and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Segments are registered. segN updates one cycle after HEX or SEG_EN changes.
  - Enabled digit: hex font, active-low. 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - Disabled digit: 7'h7F.

Test Plan:
- Reset, then read 0x0C and 0x10 -> rsp_valid exactly 1 cycle after accept, rdata 0 and 0xFF, rsp_error=0; all segN=7'h40.
- Write HEX=0x1234ABCD at BASE+0x0C, then read back -> rdata 0x1234ABCD; two edges after accept seg0=7'h21 (d), seg1=7'h46, seg7=7'h79. Write SEG_EN=0x0F -> seg4..seg7=7'h7F.
- Set switch_array=16'hA5C3, wait 3 cycles, read 0x00 -> 0x0000A5C3. Read BASE+0x02 -> rsp_error=1, rdata=0. Read BASE+0x14 -> rsp_error=1. Write to 0x00 -> no error, value unchanged.
- Glitch button1 high for DEBOUNCE_CYCLES-2 cycles -> BUTTONS reads 0, BTN_EDGE reads 0. Hold it high for DEBOUNCE_CYCLES+3 cycles -> BUTTONS=0x2, BTN_EDGE=0x2. Write 0x2 to 0x08 -> BTN_EDGE reads 0 while BUTTONS stays 0x2.
- Hold req_valid high continuously with back-to-back reads -> req_ready alternates 1/0 and one rsp_valid per accept. Drop rst low during RESP -> rsp_valid=0 on the following cycle, HEX back to 0.
